gauss_conv3x3_pipe: RTL and testbench
=====================================

# gauss_conv3x3_pipe

Pipelined, parameterised 3x3 Gaussian convolution engine for the FIR filter datapath. It takes one 3x3 pixel window per accepted beat, together with the border class from the window generator. It applies a runtime-programmable kernel with border masking, then normalises, rounds and saturates the result. Valid/ready handshakes on both sides let it sit between the line-buffer window generator and the output packer with full backpressure.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width.
- COEF_WIDTH, 4, unsigned coefficient width.
- SHIFT, 4, normalisation right-shift, 0..(ACC_W-1).
- USER_WIDTH, 1, sideband bits carried alongside each window (e.g. last/sof).
- Derived, not overridable: ACC_W = DATA_WIDTH + COEF_WIDTH + 4.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  window beat valid.
- in_ready  out  1  block can accept a beat.
- in_win  in  9*DATA_WIDTH  pixels, row-major; p[0] in LSBs (row0 col0) through p[8] (row2 col2).
- in_corner  in  4  border class: 0 null, 1 top-left, 2 top-right, 3 left edge, 4 right edge, 5 bottom-left, 6 bottom-right, 7..15 full window.
- in_user  in  USER_WIDTH  sideband, passed through aligned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  filtered pixel.
- out_user  out  USER_WIDTH  sideband of the same beat.
- coef_we  in  1  write shadow coefficient.
- coef_addr  in  4  shadow index 0..8; 9..15 ignored.
- coef_wdata  in  COEF_WIDTH  coefficient value.
- coef_commit  in  1  copy shadow set to the active set.

## Operation
- Coefficients:
  - Two register sets, shadow and active, each 9 x COEF_WIDTH.
  - Both reset to 1,2,1 / 2,4,2 / 1,2,1.
  - coef_we writes the shadow set only.
  - coef_commit copies shadow to active at that edge. Beats accepted in the same cycle use the old set; beats accepted later use the new one.
  - Simultaneous coef_we and coef_commit: the commit takes the pre-write shadow value.
- Border mask, from in_corner:
  - 0: all taps masked.
  - 1: taps 0,1,3,4.
  - 2: taps 1,2,4,5.
  - 3: taps 0,1,3,4,6,7.
  - 4: taps 1,2,4,5,7,8.
  - 5: taps 3,4,6,7.
  - 6: taps 4,5,7,8.
  - 7..15: all taps.
  - Masked taps contribute 0.
- Pipeline, 3 stages, each with its own valid bit:
  - S1 registers the 9 products p[i]*c[i], each DATA_WIDTH+COEF_WIDTH wide, with the mask applied, plus user.
  - S2 registers the 9-way sum in ACC_W, which cannot overflow.
  - S3 registers the normalised result: acc >> SHIFT, saturated to 2^DATA_WIDTH-1.
- Flow control:
  - Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall. When not stalled, every stage advances one step, bubbles included.
  - A beat transfers on in_valid & in_ready. Output completes on out_valid & out_ready.
  - While stalled, out_data, out_user and all stage contents hold.
- in_corner = 0 still produces a valid beat with out_data = 0.

## Timing
- Latency: 3 cycles from an accepted input edge to out_valid, with no stall.
- Throughput: 1 beat/cycle while out_ready is held high.
- Reset values: out_valid 0, out_data 0, out_user 0, all stage valids 0, both coefficient sets at default. in_ready is 1 once rst_n is high.
- Reset mid-operation: all in-flight beats are discarded and not emitted. Coefficients return to defaults.
- in_ready is combinational from out_ready. No other input-to-output combinational path exists.

## Configuration
- Macro: GAUSS_ROUND_EN.
  - Defined: S3 computes (acc + 2^(SHIFT-1)) >> SHIFT, round-half-up, before saturation. SHIFT = 0 adds nothing.
  - Undefined: S3 truncates, acc >> SHIFT.
- Saturation and latency are identical in both builds.

## Test plan
- All pixels 100, corner 8, default kernel, out_ready = 1 -> out_data = 100 exactly 3 cycles after acceptance, both builds.
- All pixels 100, corner 1 (weight sum 9, acc 900) -> out_data = 56. Corner 0 -> out_data = 0 with out_valid = 1.
- Centre pixel 6, others 0, corner 8 (acc 24) -> out_data = 1 without GAUSS_ROUND_EN, 2 with it.
- Load shadow coefficients all 15 and commit, all pixels 255, corner 8 (acc 34425) -> out_data saturates to 255. A beat accepted in the commit cycle still yields 255 from the old kernel (acc 4080 -> 255 truncated, 255 rounded).
- 10-beat stream with incrementing in_user; drop out_ready for 5 cycles mid-stream -> in_ready is low, out_data/out_user are stable, and all 10 beats arrive in order with no loss or duplication.
- Assert rst_n low with 3 beats in flight -> out_valid = 0 immediately. After release there are no stale outputs and the default kernel is active.

Source files
------------

// File: rtl/gauss_conv3x3_pipe.sv
// 3x3 Gaussian convolution: masked products -> 9-way sum -> normalise/saturate, with global stall.
// Build option GAUSS_ROUND_EN: round-half-up before the normalising shift (truncate otherwise).

module gauss_conv3x3_tap #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             keep,
  input  logic [DW-1:0]    pix,
  input  logic [CW-1:0]    coef,
  output logic [DW+CW-1:0] prod
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  prod <= '0;
    else if (en) prod <= keep ? (DW+CW)'(pix) * (DW+CW)'(coef) : '0;
endmodule

module gauss_conv3x3_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 4,
  parameter int SHIFT      = 4,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [9*DATA_WIDTH-1:0] in_win,
  input  logic [3:0]              in_corner,
  input  logic [USER_WIDTH-1:0]   in_user,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [USER_WIDTH-1:0]   out_user,
  input  logic                    coef_we,
  input  logic [3:0]              coef_addr,
  input  logic [COEF_WIDTH-1:0]   coef_wdata,
  input  logic                    coef_commit
);
  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + 4;
  localparam int PW     = DATA_WIDTH + COEF_WIDTH;
  localparam int STAGES = 3;
`ifdef GAUSS_ROUND_EN
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
`else
  localparam logic [ACC_W:0] RND = '0;
`endif

  function automatic logic [8:0][COEF_WIDTH-1:0] coef_dflt();
    for (int i = 0; i < 9; i++)
      coef_dflt[i] = (i == 4) ? COEF_WIDTH'(4) : (i % 2 == 0) ? COEF_WIDTH'(1) : COEF_WIDTH'(2);
  endfunction

  logic [STAGES:1]               vld_pipe;
  logic                          stall, adv, in_fire;
  logic [8:0][COEF_WIDTH-1:0]    shadow, active;
  logic [8:0]                    mask;
  logic [8:0][PW-1:0]            prod;
  logic [ACC_W-1:0]              sum, acc;
  logic [ACC_W:0]                rnd, shifted;
  logic [DATA_WIDTH-1:0]         res;
  logic [USER_WIDTH-1:0]         user1, user2;

  assign stall     = vld_pipe[STAGES] & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ~stall;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_pipe[STAGES];

  // Commit copies the pre-write shadow because both updates are non-blocking.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow <= coef_dflt();
      active <= coef_dflt();
    end else begin
      if (coef_we && coef_addr < 4'd9) shadow[coef_addr] <= coef_wdata;
      if (coef_commit) active <= shadow;
    end

  always_comb begin
    mask = 9'h1ff;
    case (in_corner)
      4'd0: mask = 9'b000_000_000;
      4'd1: mask = 9'b000_011_011;
      4'd2: mask = 9'b000_110_110;
      4'd3: mask = 9'b011_011_011;
      4'd4: mask = 9'b110_110_110;
      4'd5: mask = 9'b011_011_000;
      4'd6: mask = 9'b110_110_000;
      default: mask = 9'h1ff;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};

  for (genvar i = 0; i < 9; i++) begin : g_tap
    gauss_conv3x3_tap #(.DW(DATA_WIDTH), .CW(COEF_WIDTH)) u_tap (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv),
      .keep (mask[i]),
      .pix  (in_win[i*DATA_WIDTH +: DATA_WIDTH]),
      .coef (active[i]),
      .prod (prod[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + ACC_W'(prod[i]);
  end

  always_comb begin
    rnd     = {1'b0, acc} + RND;
    shifted = rnd >> SHIFT;
    res     = (|shifted[ACC_W:DATA_WIDTH]) ? '1 : shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      user1    <= '0;
      user2    <= '0;
      acc      <= '0;
      out_data <= '0;
      out_user <= '0;
    end else if (adv) begin
      user1    <= in_user;
      user2    <= user1;
      acc      <= sum;
      out_data <= res;
      out_user <= user2;
    end
endmodule

// File: tb/tb_gauss_conv3x3_pipe.sv
// Randomised bench for gauss_conv3x3_pipe against a row/column window model with a coefficient model.
module tb_gauss_conv3x3_pipe;
  localparam int DW = 8, CW = 4, SH = 4, UW = 4;

  logic          clk = 0, rst_n = 0;
  logic          in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [9*DW-1:0] in_win = '0;
  logic [3:0]    in_corner = '0, in_user = '0, out_user, coef_addr = '0, coef_wdata = '0;
  logic [DW-1:0] out_data;
  logic          coef_we = 0, coef_commit = 0;

  gauss_conv3x3_pipe #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .SHIFT(SH), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .in_corner(in_corner), .in_user(in_user), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_user(out_user), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_commit(coef_commit));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [UW+DW-1:0] exp_q[$], obs_q[$];
  int kdef[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  int m_sh[9], m_act[9];
  bit accepted;
`ifdef GAUSS_ROUND_EN
  localparam int C6 = 2;
`else
  localparam int C6 = 1;
`endif

  // Border class selects a rectangle of rows/columns that stays inside the image.
  function automatic logic [DW-1:0] model(logic [9*DW-1:0] w, logic [3:0] c);
    int r0 = 0, r1 = 2, c0 = 0, c1 = 2, acc = 0, res;
    case (c)
      4'd0: return '0;
      4'd1: begin r1 = 1; c1 = 1; end
      4'd2: begin r1 = 1; c0 = 1; end
      4'd3: c1 = 1;
      4'd4: c0 = 1;
      4'd5: begin r0 = 1; c1 = 1; end
      4'd6: begin r0 = 1; c0 = 1; end
      default: ;
    endcase
    for (int r = r0; r <= r1; r++)
      for (int k = c0; k <= c1; k++)
        acc += int'(w[(r*3+k)*DW +: DW]) * m_act[r*3+k];
`ifdef GAUSS_ROUND_EN
    acc += 1 << (SH - 1);
`endif
    res = acc >> SH;
    return (res > 255) ? 8'd255 : 8'(res);
  endfunction

  function automatic logic [9*DW-1:0] fill(logic [DW-1:0] v);
    return {9{v}};
  endfunction

  function automatic logic [9*DW-1:0] centre(logic [DW-1:0] v);
    logic [9*DW-1:0] w = '0;
    w[4*DW +: DW] = v;
    return w;
  endfunction

  function automatic logic [9*DW-1:0] rand_win();
    logic [9*DW-1:0] w;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = 8'($urandom);
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
    accepted = rst_n && in_valid && in_ready;
    if (rst_n && out_valid && out_ready) obs_q.push_back({out_user, out_data});
    if (accepted) exp_q.push_back({in_user, model(in_win, in_corner)});
    if (rst_n) begin
      if (coef_commit) m_act = m_sh;
      if (coef_we && coef_addr < 9) m_sh[coef_addr] = int'(coef_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic beat(logic [9*DW-1:0] w, logic [3:0] c, logic [3:0] u);
    in_valid = 1; in_win = w; in_corner = c; in_user = u;
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0; coef_we = 0; coef_commit = 0; out_ready = 1;
    while (obs_q.size() < exp_q.size() && n < 100) begin tick(); n++; end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %0d want 0", out_data); end
    total++; if (out_user !== '0) begin bad++; $display("FAIL reset_user: got %0d want 0", out_user); end
    rst_n = 1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_latency();
    beat(fill(8'd100), 4'd8, 4'd3);
    total++; if (!accepted) begin bad++; $display("FAIL lat_accept: got 0 want 1"); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_c1: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_c2: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'd100)
      begin bad++; $display("FAIL lat_c3: got v=%b d=%0d want v=1 d=100", out_valid, out_data); end
    drain();
    total++; if (obs_q.size() != 1 || obs_q[0] !== {4'd3, 8'd100})
      begin bad++; $display("FAIL lat_out: got n=%0d want 1 beat of 100", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_corners();
    int want[3] = '{56, 0, C6};
    beat(fill(8'd100), 4'd1, 4'd1);
    beat(fill(8'd100), 4'd0, 4'd2);
    beat(centre(8'd6), 4'd8, 4'd3);
    drain();
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL corner_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL corner_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      total++; if (int'(obs_q[i][DW-1:0]) != want[i]) begin bad++; $display("FAIL corner_const[%0d]: got %0d want %0d", i, obs_q[i][DW-1:0], want[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_coef();
    int want[6] = '{255, 255, 84, 10, C6, 0};
    for (int i = 0; i < 9; i++) begin coef_we = 1; coef_addr = 4'(i); coef_wdata = 4'd15; tick(); end
    coef_addr = 4'd12; coef_wdata = 4'd0; tick();
    coef_we = 0; coef_commit = 1;
    beat(fill(8'd255), 4'd8, 4'd0);
    coef_commit = 0;
    beat(fill(8'd255), 4'd8, 4'd1);
    for (int i = 0; i < 9; i++) begin coef_we = 1; coef_addr = 4'(i); coef_wdata = 4'(kdef[i]); tick(); end
    coef_we = 0; coef_commit = 1;
    beat(fill(8'd10), 4'd8, 4'd2);
    coef_commit = 0;
    beat(fill(8'd10), 4'd8, 4'd3);
    coef_we = 1; coef_addr = 4'd4; coef_wdata = 4'd0; coef_commit = 1; tick();
    coef_we = 0; coef_commit = 0;
    beat(centre(8'd6), 4'd8, 4'd4);
    coef_commit = 1; tick(); coef_commit = 0;
    beat(centre(8'd6), 4'd8, 4'd5);
    drain();
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL coef_count: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL coef_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      total++; if (int'(obs_q[i][DW-1:0]) != want[i]) begin bad++; $display("FAIL coef_const[%0d]: got %0d want %0d", i, obs_q[i][DW-1:0], want[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall();
    logic [9*DW-1:0] bw[10];
    logic [3:0] bc[10];
    logic [DW-1:0] hd = '0;
    logic [UW-1:0] hu = '0;
    int idx = 0;
    for (int i = 0; i < 10; i++) begin bw[i] = rand_win(); bc[i] = 4'($urandom_range(0, 15)); end
    for (int c = 0; c < 80 && idx < 10; c++) begin
      out_ready = !(c >= 6 && c < 11);
      in_valid = 1; in_win = bw[idx]; in_corner = bc[idx]; in_user = 4'(idx);
      #1;
      if (c == 6) begin hd = out_data; hu = out_user; end
      if (!out_ready) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c%0d: got %b want 0", c, in_ready); end
        if (c > 6) begin
          total++; if ({out_user, out_data} !== {hu, hd})
            begin bad++; $display("FAIL stall_hold c%0d: got %h want %h", c, {out_user, out_data}, {hu, hd}); end
        end
      end
      tick();
      if (accepted) idx++;
    end
    drain();
    total++; if (obs_q.size() != 10) begin bad++; $display("FAIL stall_count: got %0d want 10", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 10; i++) begin
      total++; if (obs_q[i] !== exp_q[i] || int'(obs_q[i][UW+DW-1:DW]) != i)
        begin bad++; $display("FAIL stall_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 200; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_win = rand_win(); in_corner = 4'($urandom_range(0, 15)); in_user = 4'($urandom);
      coef_we = ($urandom_range(0, 7) == 0); coef_addr = 4'($urandom_range(0, 15));
      coef_wdata = 4'($urandom); coef_commit = ($urandom_range(0, 9) == 0);
      tick();
    end
    drain();
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midflight();
    int want[2] = '{100, C6};
    coef_we = 1; coef_addr = 4'd4; coef_wdata = 4'd9; tick();
    coef_we = 0; coef_commit = 1; tick(); coef_commit = 0;
    for (int i = 0; i < 3; i++) begin in_valid = 1; in_win = rand_win(); in_corner = 4'd8; in_user = 4'(i); tick(); end
    in_valid = 0;
    rst_n = 0; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    exp_q.delete(); obs_q.delete();
    m_sh = kdef; m_act = kdef;
    repeat (2) tick();
    rst_n = 1;
    repeat (5) tick();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL midrst_stale: got %0d want 0", obs_q.size()); end
    beat(fill(8'd100), 4'd8, 4'd1);
    beat(centre(8'd6), 4'd8, 4'd2);
    drain();
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL midrst_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      total++; if (obs_q[i] !== exp_q[i] || int'(obs_q[i][DW-1:0]) != want[i])
        begin bad++; $display("FAIL midrst_beat[%0d]: got %h want %0d", i, obs_q[i], want[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    m_sh = kdef; m_act = kdef;
    test_reset();
    test_latency();
    test_corners();
    test_coef();
    test_stall();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
